// File: rtl/pix_buff_pkg.sv
// Shared constants and helpers for the pixel buffer unpacker.
// Default geometry is RGB888, ten pixels per 240-bit FIFO word, 1280x720 frames.
package pix_buff_pkg;

    localparam int unsigned PIX_WIDTH    = 24;
    localparam int unsigned PIX_PER_WORD = 10;
    localparam int unsigned DATA_WIDTH   = PIX_WIDTH * PIX_PER_WORD;
    localparam int unsigned IDX_W        = $clog2(PIX_PER_WORD);

    localparam int unsigned COL_W = $clog2(1280);
    localparam int unsigned ROW_W = $clog2(720);

    typedef logic [PIX_WIDTH-1:0] pixel_t;

    // Counter width that stays at least one bit for degenerate ranges.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_pos_cnt.sv
// Column/row position counters for the unpacked pixel stream.
// Column wraps after LINE_PIX-1 and carries into the row, which wraps after LINE_NUM-1.
module pix_pos_cnt
    import pix_buff_pkg::*;
#(
    parameter int unsigned LINE_PIX = 1280,
    parameter int unsigned LINE_NUM = 720
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic                               adv,
    output logic [cnt_width(LINE_PIX)-1:0]     col,
    output logic [cnt_width(LINE_NUM)-1:0]     row
);

    localparam int unsigned CW = cnt_width(LINE_PIX);
    localparam int unsigned RW = cnt_width(LINE_NUM);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_PIX - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(LINE_NUM - 1);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clr) begin
            col_q <= '0;
            row_q <= '0;
        end else if (adv) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/pix_buff_unpacker.sv
// Pops wide words from the show-ahead pixel FIFO and streams one pixel per clock.
// Define PIX_UNPACK_POS_EN to add column/row tracking with pix_sof/pix_eol flags.
module pix_buff_unpacker #(
    parameter int unsigned DATA_WIDTH   = pix_buff_pkg::DATA_WIDTH,
    parameter int unsigned PIX_WIDTH    = pix_buff_pkg::PIX_WIDTH,
    parameter int unsigned PIX_PER_WORD = pix_buff_pkg::PIX_PER_WORD,
    parameter int unsigned LINE_PIX     = 1280,
    parameter int unsigned LINE_NUM     = 720
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  flush,
    input  logic                  rd_vld,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [PIX_WIDTH-1:0]  pix_data,
    output logic                  pix_sof,
    output logic                  pix_eol
);

    import pix_buff_pkg::*;

    localparam int unsigned IW = cnt_width(PIX_PER_WORD);
    localparam logic [IW-1:0] IDX_LAST = IW'(PIX_PER_WORD - 1);

    if (DATA_WIDTH != PIX_WIDTH * PIX_PER_WORD) begin : g_bad_width
        $error("DATA_WIDTH must equal PIX_PER_WORD*PIX_WIDTH");
    end
    if ((LINE_PIX % PIX_PER_WORD) != 0 || LINE_NUM == 0) begin : g_bad_geom
        $error("LINE_PIX must be a multiple of PIX_PER_WORD and LINE_NUM nonzero");
    end

    logic [DATA_WIDTH-1:0] word_q;
    logic                  hold_q;
    logic [IW-1:0]         idx_q;
    logic                  accept;
    logic                  last_acc;
    logic [PIX_WIDTH-1:0]  pix_arr [PIX_PER_WORD];

    for (genvar k = 0; k < PIX_PER_WORD; k++) begin : g_slice
        assign pix_arr[k] = word_q[k*PIX_WIDTH +: PIX_WIDTH];
    end

    assign pix_valid = hold_q;
    assign pix_data  = pix_arr[idx_q];
    assign accept    = hold_q && pix_ready;
    assign last_acc  = accept && (idx_q == IDX_LAST);
    // Reset is folded in so the FIFO is never popped while the block is held in reset.
    assign rd_en     = rd_vld && rd_rst_n && !flush && (!hold_q || last_acc);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            word_q <= '0;
            hold_q <= 1'b0;
            idx_q  <= '0;
        end else if (flush) begin
            hold_q <= 1'b0;
            idx_q  <= '0;
        end else if (rd_en) begin
            word_q <= rd_data;
            hold_q <= 1'b1;
            idx_q  <= '0;
        end else if (accept) begin
            if (last_acc) begin
                hold_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

`ifdef PIX_UNPACK_POS_EN
    localparam int unsigned CW = cnt_width(LINE_PIX);
    localparam int unsigned RW = cnt_width(LINE_NUM);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    pix_pos_cnt #(
        .LINE_PIX (LINE_PIX),
        .LINE_NUM (LINE_NUM)
    ) u_pos (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .clr   (flush),
        .adv   (accept && !flush),
        .col   (col_q),
        .row   (row_q)
    );

    assign pix_eol = hold_q && (col_q == CW'(LINE_PIX - 1));
    assign pix_sof = hold_q && (col_q == '0) && (row_q == '0);
`else
    assign pix_eol = 1'b0;
    assign pix_sof = 1'b0;
`endif

endmodule

// File: tb/tb_pix_buff_unpacker.sv
// Self-checking bench for pix_buff_unpacker against a queue-based pixel stream model.
// Position flags are checked when PIX_UNPACK_POS_EN is defined, otherwise they must stay 0.
module tb_pix_buff_unpacker;

    localparam int PW  = 24;
    localparam int PPW = 10;
    localparam int DW  = PW * PPW;
    localparam int LP  = 20;
    localparam int LN  = 2;
    localparam int BW  = PW + 4;

    logic          clk = 1'b0;
    logic          rd_rst_n;
    logic          flush;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          rd_en;
    logic          pix_valid;
    logic          pix_ready;
    logic [PW-1:0] pix_data;
    logic          pix_sof;
    logic          pix_eol;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] fifo [$];
    logic [PW-1:0] mq [$];
    int            m_col = 0;
    int            m_row = 0;

    pix_buff_unpacker #(
        .DATA_WIDTH   (DW),
        .PIX_WIDTH    (PW),
        .PIX_PER_WORD (PPW),
        .LINE_PIX     (LP),
        .LINE_NUM     (LN)
    ) dut (
        .rd_clk    (clk),
        .rd_rst_n  (rd_rst_n),
        .flush     (flush),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] pattern_word(input logic [PW-1:0] base);
        logic [DW-1:0] w;
        for (int k = 0; k < PPW; k++) w[k*PW +: PW] = base + PW'(k);
        return w;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < PPW; k++) w[k*PW +: PW] = PW'($urandom);
        return w;
    endfunction

    function automatic logic [PW-1:0] pix_of(input logic [DW-1:0] w, input int k);
        return w[k*PW +: PW];
    endfunction

    // One clock: drive inputs, predict from the model, sample the DUT, then advance the model.
    task automatic tick(input bit gate, input bit rdy, input bit fl,
                        output logic [BW-1:0] exp_v, output logic [BW-1:0] obs_v);
        logic          e_valid, e_acc, e_rden, e_sof, e_eol;
        logic [PW-1:0] e_data;
        logic [DW-1:0] head;
        @(negedge clk);
        head      = (fifo.size() > 0) ? fifo[0] : '0;
        rd_vld    = gate && (fifo.size() > 0);
        rd_data   = head;
        pix_ready = rdy;
        flush     = fl;
        #1;
        e_valid = (mq.size() != 0);
        e_acc   = e_valid && rdy;
        e_rden  = rd_vld && !fl && (!e_valid || (e_acc && mq.size() == 1));
        e_data  = e_valid ? mq[0] : '0;
`ifdef PIX_UNPACK_POS_EN
        e_eol = e_valid && (m_col == LP - 1);
        e_sof = e_valid && (m_col == 0) && (m_row == 0);
`else
        e_eol = 1'b0;
        e_sof = 1'b0;
`endif
        exp_v = {e_rden, e_valid, e_sof, e_eol, e_data};
        obs_v = {rd_en, pix_valid, pix_sof, pix_eol, (e_valid ? pix_data : PW'(0))};
        @(posedge clk);
        if (rd_en && fifo.size() > 0) void'(fifo.pop_front());
        if (fl) begin
            mq.delete();
            m_col = 0;
            m_row = 0;
        end else begin
            if (e_acc) begin
                void'(mq.pop_front());
                m_col++;
                if (m_col == LP) begin
                    m_col = 0;
                    m_row = (m_row + 1) % LN;
                end
            end
            if (e_rden) for (int k = 0; k < PPW; k++) mq.push_back(pix_of(head, k));
        end
    endtask

    task automatic test_reset();
        logic [BW-1:0] o;
        rd_rst_n  = 1'b0;
        flush     = 1'b0;
        pix_ready = 1'b1;
        fifo.push_back(pattern_word(24'h0B0000));
        rd_vld  = 1'b1;
        rd_data = fifo[0];
        repeat (2) @(negedge clk);
        #1;
        o = {rd_en, pix_valid, pix_sof, pix_eol, pix_data};
        tests++;
        if (o !== '0) begin
            $display("FAIL reset_outputs got=%h exp=%h", o, {BW{1'b0}});
            fails++;
        end
        @(negedge clk);
        rd_vld   = 1'b0;
        rd_rst_n = 1'b1;
        fifo.delete();
        mq.delete();
        m_col = 0;
        m_row = 0;
    endtask

    task automatic test_single_word();
        logic [BW-1:0] e, o;
        int n_rden = 0;
        fifo.push_back(pattern_word(24'h0A0000));
        for (int c = 0; c < 13; c++) begin
            tick(1'b1, 1'b1, 1'b0, e, o);
            tests++;
            if (o !== e) begin
                $display("FAIL single_cyc%0d got=%h exp=%h", c, o, e);
                fails++;
            end
            if (o[BW-1]) n_rden++;
            if (c >= 1 && c <= 10) begin
                tests++;
                if (o[BW-2] !== 1'b1 || o[PW-1:0] !== PW'(32'h0A0000 + c - 1)) begin
                    $display("FAIL single_pix%0d got=%h exp=%h", c - 1, o[PW-1:0],
                             PW'(32'h0A0000 + c - 1));
                    fails++;
                end
            end
        end
        tests++;
        if (n_rden != 1) begin
            $display("FAIL single_rden_pulses got=%0d exp=1", n_rden);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] e, o;
        string rden_at = "";
        int    n_valid = 0;
        repeat (3) fifo.push_back(rand_word());
        for (int c = 0; c < 34; c++) begin
            tick(1'b1, 1'b1, 1'b0, e, o);
            tests++;
            if (o !== e) begin
                $display("FAIL b2b_cyc%0d got=%h exp=%h", c, o, e);
                fails++;
            end
            if (o[BW-1]) rden_at = {rden_at, $sformatf("%0d ", c)};
            if (c >= 1 && c <= 30 && o[BW-2]) n_valid++;
        end
        tests++;
        if (rden_at != "0 10 20 ") begin
            $display("FAIL b2b_rden_cycles got=%s exp=0 10 20", rden_at);
            fails++;
        end
        tests++;
        if (n_valid != 30) begin
            $display("FAIL b2b_no_gap got=%0d exp=30", n_valid);
            fails++;
        end
    endtask

    task automatic test_stall();
        logic [BW-1:0] e, o;
        logic [DW-1:0] w1;
        w1 = rand_word();
        fifo.push_back(w1);
        fifo.push_back(rand_word());
        for (int c = 0; c < 29; c++) begin
            tick(1'b1, !(c >= 5 && c <= 9), 1'b0, e, o);
            tests++;
            if (o !== e) begin
                $display("FAIL stall_cyc%0d got=%h exp=%h", c, o, e);
                fails++;
            end
            if (c >= 5 && c <= 10) begin
                tests++;
                if (o[BW-1] !== 1'b0 || o[BW-2] !== 1'b1 || o[PW-1:0] !== pix_of(w1, 4)) begin
                    $display("FAIL stall_hold%0d got=%h exp_pix=%h", c, o, pix_of(w1, 4));
                    fails++;
                end
            end
            if (c == 11) begin
                tests++;
                if (o[PW-1:0] !== pix_of(w1, 5)) begin
                    $display("FAIL stall_resume got=%h exp=%h", o[PW-1:0], pix_of(w1, 5));
                    fails++;
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [BW-1:0] e, o;
        logic [DW-1:0] w2;
        w2 = rand_word();
        fifo.push_back(rand_word());
        fifo.push_back(w2);
        for (int c = 0; c < 21; c++) begin
            tick(1'b1, 1'b1, c == 7, e, o);
            tests++;
            if (o !== e) begin
                $display("FAIL flush_cyc%0d got=%h exp=%h", c, o, e);
                fails++;
            end
            if (c == 7) begin
                tests++;
                if (o[BW-1] !== 1'b0) begin
                    $display("FAIL flush_no_pop got=%b exp=0", o[BW-1]);
                    fails++;
                end
            end
            if (c == 8) begin
                tests++;
                if (o[BW-2] !== 1'b0) begin
                    $display("FAIL flush_valid_drop got=%b exp=0", o[BW-2]);
                    fails++;
                end
            end
            if (c == 9) begin
                tests++;
                if (o[BW-2] !== 1'b1 || o[PW-1:0] !== pix_of(w2, 0)) begin
                    $display("FAIL flush_next_idx0 got=%h exp=%h", o[PW-1:0], pix_of(w2, 0));
                    fails++;
                end
            end
        end
    endtask

    task automatic test_position();
        logic [BW-1:0] e, o;
        string sof_at = "";
        string eol_at = "";
        string exp_sof, exp_eol;
        int    n = 0;
`ifdef PIX_UNPACK_POS_EN
        exp_sof = "0 40 ";
        exp_eol = "19 39 ";
`else
        exp_sof = "";
        exp_eol = "";
`endif
        tick(1'b0, 1'b1, 1'b1, e, o);
        tests++;
        if (o !== e) begin
            $display("FAIL pos_clear got=%h exp=%h", o, e);
            fails++;
        end
        for (int w = 0; w < 5; w++) fifo.push_back(pattern_word(PW'(32'h100000 + w * 16)));
        for (int c = 0; c < 56; c++) begin
            tick(1'b1, 1'b1, 1'b0, e, o);
            tests++;
            if (o !== e) begin
                $display("FAIL pos_cyc%0d got=%h exp=%h", c, o, e);
                fails++;
            end
            if (o[BW-2]) begin
                if (o[BW-3]) sof_at = {sof_at, $sformatf("%0d ", n)};
                if (o[BW-4]) eol_at = {eol_at, $sformatf("%0d ", n)};
                n++;
            end
        end
        tests++;
        if (sof_at != exp_sof) begin
            $display("FAIL pos_sof_accepts got=%s exp=%s", sof_at, exp_sof);
            fails++;
        end
        tests++;
        if (eol_at != exp_eol) begin
            $display("FAIL pos_eol_accepts got=%s exp=%s", eol_at, exp_eol);
            fails++;
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] e, o;
        for (int c = 0; c < 600; c++) begin
            if (fifo.size() < 2 && $urandom_range(0, 3) != 0) fifo.push_back(rand_word());
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 49) == 0, e, o);
            tests++;
            if (o !== e) begin
                $display("FAIL random_cyc%0d got=%h exp=%h", c, o, e);
                fails++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] e, o;
        logic [DW-1:0] w2;
        fifo.delete();
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 1'b1, 1'b0, e, o);
            tests++;
            if (o !== e) begin
                $display("FAIL rstmid_drain%0d got=%h exp=%h", c, o, e);
                fails++;
            end
        end
        w2 = rand_word();
        fifo.push_back(rand_word());
        fifo.push_back(w2);
        for (int c = 0; c < 5; c++) begin
            tick(1'b1, 1'b1, 1'b0, e, o);
            tests++;
            if (o !== e) begin
                $display("FAIL rstmid_pre%0d got=%h exp=%h", c, o, e);
                fails++;
            end
        end
        @(negedge clk);
        rd_vld   = 1'b1;
        rd_data  = fifo[0];
        rd_rst_n = 1'b0;
        #1;
        o = {rd_en, pix_valid, pix_sof, pix_eol, pix_data};
        tests++;
        if (o !== '0) begin
            $display("FAIL rstmid_outputs got=%h exp=%h", o, {BW{1'b0}});
            fails++;
        end
        mq.delete();
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rd_vld   = 1'b0;
        rd_rst_n = 1'b1;
        for (int c = 0; c < 13; c++) begin
            tick(1'b1, 1'b1, 1'b0, e, o);
            tests++;
            if (o !== e) begin
                $display("FAIL rstmid_post%0d got=%h exp=%h", c, o, e);
                fails++;
            end
            if (c == 1) begin
                tests++;
                if (o[BW-2] !== 1'b1 || o[PW-1:0] !== pix_of(w2, 0)) begin
                    $display("FAIL rstmid_fresh_word got=%h exp=%h", o[PW-1:0], pix_of(w2, 0));
                    fails++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_flush();
        test_position();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
